// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable half-period clock dividers.
// Optional global phase realign via `DIVBANK_SYNC_EN (adds the sync port).
module clk_div_bank #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 28,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = '0
) (
  input  logic              clk100Mhz,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef DIVBANK_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pend
);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] pdiv_q, pdiv_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en && (wr_ch == 4'(i));
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (div_q[i] == '0) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          pend_d[i] = 1'b0;
        end
        if (wr_hit[i]) begin
          div_d[i] = wr_div;
        end
      end else begin
        if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
          if (pend_q[i]) begin
            div_d[i]  = pdiv_q[i];
            pend_d[i] = 1'b0;
            // a pending zero turns the channel off at this edge
            if (pdiv_q[i] == '0) begin
              clk_d[i]  = 1'b0;
              tick_d[i] = 1'b0;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        if (wr_hit[i]) begin
          pdiv_d[i] = wr_div;
          pend_d[i] = 1'b1;
        end
      end
`ifdef DIVBANK_SYNC_EN
      if (sync) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        pend_d[i] = 1'b0;
        div_d[i]  = pend_q[i] ? pdiv_q[i] : div_q[i];
        if (wr_hit[i]) begin
          div_d[i] = wr_div;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DIV_INIT;
      pdiv_q <= '0;
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign div_pend = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed table-driven bench for clk_div_bank (4 channels, 8-bit).
// Divisors at reset: ch0=1, ch1=2, ch2=3, ch3=0 (off).
module tb_clk_div_bank;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_ch;
  logic [7:0] wr_div;
`ifdef DIVBANK_SYNC_EN
  logic       sync;
`endif
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] div_pend;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       we;
    logic [3:0] ch;
    logic [7:0] dv;
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [3:0] e_pend;
  } vec_t;

  vec_t vq[$];

  clk_div_bank #(
    .NUM_CH(4),
    .CNT_W(8),
    .DIV_INIT({8'd0, 8'd3, 8'd2, 8'd1})
  ) dut (
    .clk100Mhz(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
`ifdef DIVBANK_SYNC_EN
    .sync(sync),
`endif
    .clk_out(clk_out),
    .tick(tick),
    .div_pend(div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] ec,
                     input logic [3:0] et, input logic [3:0] ep);
    checks++;
    if ({clk_out, tick, div_pend} !== {ec, et, ep}) begin
      errors++;
      $display("FAIL %s: got clk=%b tick=%b pend=%b want clk=%b tick=%b pend=%b",
               nm, clk_out, tick, div_pend, ec, et, ep);
    end
  endtask

  task automatic add(input logic we, input logic [3:0] ch,
                     input logic [7:0] dv, input logic [3:0] c,
                     input logic [3:0] t, input logic [3:0] p);
    vec_t v;
    v.we = we; v.ch = ch; v.dv = dv;
    v.e_clk = c; v.e_tick = t; v.e_pend = p;
    vq.push_back(v);
  endtask

  task automatic apply(input int i);
    wr_en  = vq[i].we;
    wr_ch  = vq[i].ch;
    wr_div = vq[i].dv;
    step();
    chk($sformatf("row%0d", i), vq[i].e_clk, vq[i].e_tick, vq[i].e_pend);
  endtask

  initial begin
    // free running after reset
    add(0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0010, 4'b0010, 4'b0000);
    add(0, 0, 0, 4'b0111, 4'b0101, 4'b0000);
    add(0, 0, 0, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0101, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0010, 4'b0010, 4'b0000);
    add(0, 0, 0, 4'b0011, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    // ch1 <= 5 mid half-period
    add(1, 1, 5, 4'b0101, 4'b0101, 4'b0010);
    add(0, 0, 0, 4'b0110, 4'b0010, 4'b0000);
    add(0, 0, 0, 4'b0111, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0011, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0010, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0101, 4'b0101, 4'b0000);
    add(0, 0, 0, 4'b0100, 4'b0000, 4'b0000);
    // ch3 <= 4 while off
    add(1, 3, 4, 4'b0101, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    add(0, 0, 0, 4'b0010, 4'b0010, 4'b0000);
    add(0, 0, 0, 4'b1111, 4'b1101, 4'b0000);
    // ch0 <= 0 while high, then an out-of-range write
    add(1, 0, 0, 4'b1110, 4'b0000, 4'b0001);
    add(0, 0, 0, 4'b1110, 4'b0000, 4'b0000);
    add(1, 7, 9, 4'b1010, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0100, 4'b0100, 4'b0000);
    add(0, 0, 0, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b1100, 4'b1000, 4'b0000);
    add(0, 0, 0, 4'b1010, 4'b0010, 4'b0000);

    rst_n  = 1'b0;
    wr_en  = 1'b0;
    wr_ch  = 4'd0;
    wr_div = 8'd0;
`ifdef DIVBANK_SYNC_EN
    sync   = 1'b0;
`endif
    step();
    step();
    chk("reset", 4'b0000, 4'b0000, 4'b0000);

    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) apply(i);

    // pending write to ch1, then a one-cycle reset
    wr_en  = 1'b1;
    wr_ch  = 4'd1;
    wr_div = 8'd7;
    step();
    chk("pend_ch1", 4'b1010, 4'b0000, 4'b0010);
    wr_en = 1'b0;
    rst_n = 1'b0;
    step();
    chk("reset_mid", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) apply(i);

`ifdef DIVBANK_SYNC_EN
    step();
    chk("pre_sync", 4'b0101, 4'b0101, 4'b0000);
    sync   = 1'b1;
    wr_en  = 1'b1;
    wr_ch  = 4'd2;
    wr_div = 8'd2;
    step();
    chk("sync_edge", 4'b0000, 4'b0000, 4'b0000);
    sync  = 1'b0;
    wr_en = 1'b0;
    step();
    chk("sync_p1", 4'b0001, 4'b0001, 4'b0000);
    step();
    chk("sync_p2", 4'b0110, 4'b0110, 4'b0000);
    step();
    chk("sync_p3", 4'b0111, 4'b0001, 4'b0000);
    step();
    chk("sync_p4", 4'b0000, 4'b0000, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
